// File: rtl/aes_round_counter.sv
// Round counter for the AES datapath.
// Counts 0..MAX_CNT on enabled clocks, wraps to 0 after MAX_CNT, and flags the
// terminal (last) round combinationally from the count register.
module aes_round_counter #(
    parameter int MAX_CNT  = 10,
    parameter int CNT_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cnt_en,
    output logic                o_flag,
    output logic [CNT_SIZE-1:0] o_count
);

    // Refuse to build a counter whose terminal value is zero or does not fit
    // in the count register; either would break the wrap/flag behaviour.
    generate
        if (MAX_CNT < 1) begin : g_bad_max_low
            $error("aes_round_counter: MAX_CNT must be >= 1");
        end
        if (CNT_SIZE < 1 || CNT_SIZE > 31) begin : g_bad_size
            $error("aes_round_counter: CNT_SIZE must be in 1..31");
        end else if (MAX_CNT > (2 ** CNT_SIZE) - 1) begin : g_bad_max_high
            $error("aes_round_counter: MAX_CNT does not fit in CNT_SIZE bits");
        end
    endgenerate

    localparam logic [CNT_SIZE-1:0] TERM_VAL = CNT_SIZE'(MAX_CNT);
    localparam logic [CNT_SIZE-1:0] ONE_VAL  = CNT_SIZE'(1);

    logic [CNT_SIZE-1:0] count_q;
    logic [CNT_SIZE-1:0] count_d;
    logic                at_term;

    // Terminal detect, shared by the wrap decision and the output flag.
    assign at_term = (count_q == TERM_VAL);

    // Next-count selection: wrap at the terminal value, otherwise step or hold.
    always_comb begin
        count_d = count_q;
        if (i_cnt_en) begin
            if (at_term) begin
                count_d = '0;
            end else begin
                count_d = count_q + ONE_VAL;
            end
        end
    end

    // Count register; reset wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_flag  = at_term;

endmodule

// File: tb/tb_aes_round_counter.sv
// Self-checking bench for aes_round_counter: table-driven run, hand-written
// corner sequences, and a randomized run against an arithmetic reference.
module tb_aes_round_counter;

    logic       clk;
    logic       rst_n;
    logic       i_cnt_en;
    logic       flag10;
    logic [3:0] cnt10;
    logic       flag13;
    logic [3:0] cnt13;

    int checks;
    int errors;
    int m10;
    int m13;

    typedef struct {
        bit rst_n;
        bit en;
        int exp_cnt;
        bit exp_flag;
    } vec_t;

    vec_t vecs[$];

    aes_round_counter #(.MAX_CNT(10), .CNT_SIZE(4)) dut10 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cnt_en (i_cnt_en),
        .o_flag   (flag10),
        .o_count  (cnt10)
    );

    aes_round_counter #(.MAX_CNT(13), .CNT_SIZE(4)) dut13 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cnt_en (i_cnt_en),
        .o_flag   (flag13),
        .o_count  (cnt13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Drive inputs, take one rising edge, advance the reference counts.
    task automatic tick(input bit r, input bit e);
        rst_n    = r;
        i_cnt_en = e;
        @(posedge clk);
        if (!r) begin
            m10 = 0;
            m13 = 0;
        end else if (e) begin
            m10 = (m10 + 1) % 11;
            m13 = (m13 + 1) % 14;
        end
        #1;
    endtask

    task automatic check_models(input string tag);
        check({tag, " cnt10"},  int'(cnt10),  m10);
        check({tag, " flag10"}, int'(flag10), (m10 == 10) ? 1 : 0);
        check({tag, " cnt13"},  int'(cnt13),  m13);
        check({tag, " flag13"}, int'(flag13), (m13 == 13) ? 1 : 0);
    endtask

    task automatic check10(input string tag, input int c, input int f);
        check({tag, " cnt"},  int'(cnt10),  c);
        check({tag, " flag"}, int'(flag10), f);
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        errors   = 0;
        m10      = 0;
        m13      = 0;
        rst_n    = 1'b0;
        i_cnt_en = 1'b0;

        // Table: 5 reset cycles, then two full periods with enable held high.
        for (int i = 0; i < 5; i++) begin
            v = '{rst_n: 1'b0, en: 1'b0, exp_cnt: 0, exp_flag: 1'b0};
            vecs.push_back(v);
        end
        for (int i = 1; i <= 22; i++) begin
            v.rst_n    = 1'b1;
            v.en       = 1'b1;
            v.exp_cnt  = i % 11;
            v.exp_flag = ((i % 11) == 10);
            vecs.push_back(v);
        end

        foreach (vecs[i]) begin
            tick(vecs[i].rst_n, vecs[i].en);
            check($sformatf("vec%0d cnt", i),  int'(cnt10),  vecs[i].exp_cnt);
            check($sformatf("vec%0d flag", i), int'(flag10), int'(vecs[i].exp_flag));
            check($sformatf("vec%0d cnt13", i), int'(cnt13), m13);
        end

        // Hold mid-count: 4 enables, 3 idle cycles, resume at 5.
        tick(1'b0, 1'b0);
        check10("hold reset", 0, 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        check10("hold at4", 4, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            check10($sformatf("hold idle%0d", i), 4, 0);
        end
        tick(1'b1, 1'b1);
        check10("hold resume", 5, 0);

        // Hold at terminal: flag stays high while frozen, then wraps.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        check10("term reach", 10, 1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0);
            check10($sformatf("term idle%0d", i), 10, 1);
        end
        tick(1'b1, 1'b1);
        check10("term wrap", 0, 0);

        // Reset priority over enable, then release with enable high.
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
        check10("rstpri at7", 7, 0);
        tick(1'b0, 1'b1);
        check10("rstpri clr", 0, 0);
        tick(1'b1, 1'b1);
        check10("rstpri rel", 1, 0);

        // Reset while flag high drops flag on the same edge.
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b1);
        check10("rstterm at10", 10, 1);
        tick(1'b0, 1'b1);
        check10("rstterm clr", 0, 0);

        // MAX_CNT = 13 sweep: period 14, flag only at 13.
        tick(1'b0, 1'b0);
        for (int i = 1; i <= 28; i++) begin
            tick(1'b1, 1'b1);
            check($sformatf("sweep13 cnt %0d", i), int'(cnt13), i % 14);
            check($sformatf("sweep13 flag %0d", i), int'(flag13), ((i % 14) == 13) ? 1 : 0);
        end

        // Randomized run against the arithmetic reference.
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0));
            check_models($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
